// File: rtl/axis_tg_multimode.sv
// AXI-Stream NoC traffic generator: multi-flit packets, four destination patterns,
// LFSR-driven Bernoulli injection with a per-run packet budget.
module axis_tg_multimode #(
  parameter int          TDATA_WIDTH   = 64,
  parameter int          TDEST_WIDTH   = 4,
  parameter int          TID_WIDTH     = 4,
  parameter int          COUNT_WIDTH   = 32,
  parameter int          TICK_WIDTH    = 32,
  parameter int          NUM_ROUTERS   = 16,
  parameter int          TID           = 0,
  parameter logic [15:0] SEED          = 16'd1,
  parameter int          MAX_PKT_FLITS = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [15:0]                          load,
  input  logic [1:0]                           mode,
  input  logic [TDEST_WIDTH-1:0]               hotspot_dest,
  input  logic [$clog2(MAX_PKT_FLITS+1)-1:0]   pkt_flits,
  input  logic [COUNT_WIDTH-1:0]               num_packets,
  input  logic                                 start,
  input  logic [TICK_WIDTH-1:0]                ticks,
  output logic                                 done,
  output logic [COUNT_WIDTH-1:0]               total_sent_packets,
  output logic                                 axis_out_tvalid,
  input  logic                                 axis_out_tready,
  output logic [TDATA_WIDTH-1:0]               axis_out_tdata,
  output logic                                 axis_out_tlast,
  output logic [TID_WIDTH-1:0]                 axis_out_tid,
  output logic [TDEST_WIDTH-1:0]               axis_out_tdest
);

  localparam int          FW       = $clog2(MAX_PKT_FLITS + 1);
  localparam int          KW       = TDATA_WIDTH - TICK_WIDTH - COUNT_WIDTH;
  localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'd1 : SEED;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_SEND,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [15:0]              lfsr_q, lfsr_d;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]            flits_q, flits_d;
  logic [FW-1:0]            k_q, k_d;
  logic [TICK_WIDTH-1:0]    ts_q, ts_d;
  logic [TDEST_WIDTH-1:0]   dest_q, dest_d;
  logic                     tvalid_q, tvalid_d;
  logic                     tlast_q, tlast_d;
  logic                     done_q, done_d;

  logic [15:0]              lfsr_next;
  logic [FW-1:0]            flits_clamped;
  logic [TDEST_WIDTH-1:0]   uni_dest;
  logic [TDEST_WIDTH-1:0]   dest_pick;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11; a nonzero state never reaches 0.
  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  assign uni_dest = TDEST_WIDTH'({24'd0, lfsr_q[15:8]} % 32'(NUM_ROUTERS));

  always_comb begin
    flits_clamped = pkt_flits;
    if (pkt_flits == '0) begin
      flits_clamped = FW'(1);
    end else if (pkt_flits > FW'(MAX_PKT_FLITS)) begin
      flits_clamped = FW'(MAX_PKT_FLITS);
    end
  end

  always_comb begin
    dest_pick = uni_dest;
    case (mode)
      2'd1:    dest_pick = hotspot_dest;
      2'd2:    dest_pick = TDEST_WIDTH'(NUM_ROUTERS - 1 - TID);
      2'd3:    dest_pick = (lfsr_q[2:0] == 3'd0) ? hotspot_dest : uni_dest;
      default: dest_pick = uni_dest;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    flits_d  = flits_q;
    k_d      = k_q;
    ts_d     = ts_q;
    dest_d   = dest_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    done_d   = done_q;

    if (state_q != S_IDLE) begin
      lfsr_d = lfsr_next;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARB;
        end
      end

      S_ARB: begin
        if (cnt_q == num_packets) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (!start) begin
          state_d = S_IDLE;
        end else if (lfsr_q <= load) begin
          state_d  = S_SEND;
          flits_d  = flits_clamped;
          k_d      = '0;
          ts_d     = ticks;
          dest_d   = dest_pick;
          tvalid_d = 1'b1;
          tlast_d  = (flits_clamped == FW'(1));
        end
      end

      S_SEND: begin
        // tvalid is always high here, so tready alone marks the handshake.
        if (axis_out_tready) begin
          if (tlast_q) begin
            cnt_d    = cnt_q + COUNT_WIDTH'(1);
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = S_ARB;
          end else begin
            k_d     = k_q + FW'(1);
            tlast_d = ((k_q + FW'(1)) == (flits_q - FW'(1)));
          end
        end
      end

      S_DONE: begin
        if (!start) begin
          done_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED_EFF;
      cnt_q    <= '0;
      flits_q  <= '0;
      k_q      <= '0;
      ts_q     <= '0;
      dest_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      flits_q  <= flits_d;
      k_q      <= k_d;
      ts_q     <= ts_d;
      dest_q   <= dest_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
    end
  end

  // The header is assembled from registers that only change between packets, so it
  // stays stable under backpressure; the flit index fills whatever MSBs remain.
  generate
    if (KW > 0) begin : g_with_index
      assign axis_out_tdata = {KW'(k_q), cnt_q, ts_q};
    end else begin : g_no_index
      assign axis_out_tdata = {cnt_q, ts_q};
    end
  endgenerate

  assign axis_out_tvalid    = tvalid_q;
  assign axis_out_tlast     = tlast_q;
  assign axis_out_tdest     = dest_q;
  assign axis_out_tid       = TID_WIDTH'(TID);
  assign done               = done_q;
  assign total_sent_packets = cnt_q;

endmodule

// File: tb/tb_axis_tg_multimode.sv
// Self-checking bench for axis_tg_multimode: a packet-level reference model predicts
// every injection cycle, header and destination from the LFSR sequence and bench-driven tready.
module tb_axis_tg_multimode;

  localparam int          TDW  = 64;
  localparam int          DW   = 4;
  localparam int          IW   = 4;
  localparam int          CW   = 16;
  localparam int          TW   = 24;
  localparam int          NR   = 16;
  localparam int          TIDV = 3;
  localparam int          MAXF = 8;
  localparam int          FW   = $clog2(MAXF + 1);
  localparam int          KW   = TDW - CW - TW;
  localparam logic [15:0] SEED = 16'd0;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [15:0]     load;
  logic [1:0]      mode;
  logic [DW-1:0]   hotspot_dest;
  logic [FW-1:0]   pkt_flits;
  logic [CW-1:0]   num_packets;
  logic            start;
  logic [TW-1:0]   ticks;
  logic            done;
  logic [CW-1:0]   total_sent_packets;
  logic            tvalid;
  logic            tready;
  logic [TDW-1:0]  tdata;
  logic            tlast;
  logic [IW-1:0]   tid;
  logic [DW-1:0]   tdest;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_tg_multimode #(
    .TDATA_WIDTH(TDW), .TDEST_WIDTH(DW), .TID_WIDTH(IW), .COUNT_WIDTH(CW),
    .TICK_WIDTH(TW), .NUM_ROUTERS(NR), .TID(TIDV), .SEED(SEED), .MAX_PKT_FLITS(MAXF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .mode(mode), .hotspot_dest(hotspot_dest),
    .pkt_flits(pkt_flits), .num_packets(num_packets), .start(start), .ticks(ticks),
    .done(done), .total_sent_packets(total_sent_packets),
    .axis_out_tvalid(tvalid), .axis_out_tready(tready), .axis_out_tdata(tdata),
    .axis_out_tlast(tlast), .axis_out_tid(tid), .axis_out_tdest(tdest)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [DW-1:0] exp_dest(input int md, input logic [15:0] lf,
                                             input logic [DW-1:0] hot);
    int uni;
    uni = int'(lf[15:8]) % NR;
    case (md)
      0:       return DW'(uni);
      1:       return hot;
      2:       return DW'(NR - 1 - TIDV);
      default: return (lf[2:0] == 3'd0) ? hot : DW'(uni);
    endcase
  endfunction

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    ticks = ticks + TW'(1);
  endtask

  task automatic run(input int md, input logic [15:0] ld, input int hot_in, input int pf,
                     input int npk, input int rdy_pct, input int stall_k, input int abort_k,
                     input int drop_pkt, input int cap, output int hot_hits);
    logic [15:0]   lf;
    logic [DW-1:0] hot, dst;
    logic [TW-1:0] ts;
    logic [63:0]   exp_data;
    int fl, k, cnt, iter, stall_left;
    bit rdy, fin;

    hot          = DW'(hot_in);
    hot_hits     = 0;
    rst_n        = 1'b0;
    mode         = 2'(md);
    load         = ld;
    hotspot_dest = hot;
    pkt_flits    = FW'(pf);
    num_packets  = CW'(npk);
    start        = 1'b1;
    tready       = 1'b0;
    #1;
    check("rst_tvalid", 64'(tvalid), 64'(0));
    check("rst_tlast",  64'(tlast),  64'(0));
    check("rst_done",   64'(done),   64'(0));
    check("rst_tdata",  64'(tdata),  64'(0));
    check("rst_tdest",  64'(tdest),  64'(0));
    check("rst_total",  64'(total_sent_packets), 64'(0));
    check("rst_tid",    64'(tid),    64'(TIDV));
    tick();
    rst_n = 1'b1;
    tick();

    lf   = (SEED == 16'd0) ? 16'd1 : SEED;
    fl   = (pf == 0) ? 1 : ((pf > MAXF) ? MAXF : pf);
    cnt  = 0;
    iter = 0;
    fin  = 1'b0;
    while (!fin) begin
      // Arbitration cycle.
      if (iter >= cap) start = 1'b0;
      iter++;
      tready = ($urandom_range(99) < rdy_pct);
      check("arb_tvalid", 64'(tvalid), 64'(0));
      check("arb_done",   64'(done),   64'(0));
      check("arb_total",  64'(total_sent_packets), 64'(cnt));
      if (cnt == npk) begin
        tick();
        check("done_set",    64'(done),   64'(1));
        check("done_tvalid", 64'(tvalid), 64'(0));
        check("done_total",  64'(total_sent_packets), 64'(cnt));
        tick();
        check("done_hold",   64'(done),   64'(1));
        start = 1'b0;
        tick();
        check("done_clear",     64'(done), 64'(0));
        check("done_total_clr", 64'(total_sent_packets), 64'(0));
        fin = 1'b1;
      end else if (!start) begin
        tick();
        repeat (3) begin
          check("idle_tvalid", 64'(tvalid), 64'(0));
          check("idle_done",   64'(done),   64'(0));
          check("idle_total",  64'(total_sent_packets), 64'(cnt));
          tick();
        end
        fin = 1'b1;
      end else if (lf <= ld) begin
        dst = exp_dest(md, lf, hot);
        ts  = ticks;
        tick();
        lf = lfsr_step(lf);
        k = 0;
        stall_left = (stall_k >= 0) ? 10 : 0;
        while (k < fl) begin
          if (k == stall_k && stall_left > 0) begin
            tready = 1'b0;
            stall_left--;
          end else begin
            tready = ($urandom_range(99) < rdy_pct);
          end
          if (k == 0 && cnt == drop_pkt) start = 1'b0;
          exp_data = {KW'(k), CW'(cnt), ts};
          check("tx_tvalid", 64'(tvalid), 64'(1));
          check("tx_tdata",  tdata, exp_data);
          check("tx_tdest",  64'(tdest), 64'(dst));
          check("tx_tlast",  64'(tlast), 64'(k == fl - 1));
          check("tx_total",  64'(total_sent_packets), 64'(cnt));
          check("tx_done",   64'(done), 64'(0));
          if (k == abort_k) begin
            #2 rst_n = 1'b0;
            #1;
            check("abort_tvalid", 64'(tvalid), 64'(0));
            check("abort_tlast",  64'(tlast),  64'(0));
            check("abort_tdata",  64'(tdata),  64'(0));
            check("abort_tdest",  64'(tdest),  64'(0));
            check("abort_total",  64'(total_sent_packets), 64'(0));
            check("abort_done",   64'(done),   64'(0));
            $display("run mode=%0d load=%04h flits=%0d packets=%0d aborted at flit %0d",
                     md, ld, fl, npk, k);
            return;
          end
          rdy = tready;
          if (rdy && k == fl - 1 && tdest == hot) hot_hits++;
          tick();
          lf = lfsr_step(lf);
          if (rdy) k++;
        end
        cnt++;
      end else begin
        tick();
        lf = lfsr_step(lf);
      end
    end
    $display("run mode=%0d load=%04h flits=%0d packets=%0d sent=%0d arb_cycles=%0d hot_hits=%0d",
             md, ld, fl, npk, cnt, iter, hot_hits);
  endtask

  initial begin
    int hh;
    int pct;
    int big;
    big    = 1 << 30;
    rst_n  = 1'b0;
    ticks  = '0;
    tready = 1'b0;
    start  = 1'b0;

    // Fixed destination, single-flit packets at full load: one flit every two cycles.
    run(1, 16'hFFFF, 5, 1, 4, 100, -1, -1, -1, big, hh);
    // Zero load never injects.
    run(0, 16'h0000, 2, 2, 4, 100, -1, -1, -1, 1000, hh);
    // Ten-cycle stall on the middle flit of a 3-flit packet.
    run(0, 16'hFFFF, 7, 3, 3, 100, 1, -1, -1, big, hh);
    // Complement pattern with clamped flit counts.
    run(2, 16'hFFFF, 0, 0, 4, 60, -1, -1, -1, big, hh);
    run(2, 16'hFFFF, 0, MAXF + 1, 3, 60, -1, -1, -1, big, hh);
    // Empty run goes straight to done.
    run(0, 16'hFFFF, 0, 2, 0, 100, -1, -1, -1, big, hh);
    // Start dropped during packet 1: it completes, then the generator idles.
    run(2, 16'hFFFF, 0, 3, 5, 70, -1, -1, 1, big, hh);
    // Reset during flit 1 of a 4-flit packet, then a fresh run.
    run(1, 16'hFFFF, 9, 4, 3, 100, -1, 1, -1, big, hh);
    run(1, 16'hFFFF, 9, 4, 2, 100, -1, -1, -1, big, hh);

    for (int r = 0; r < 6; r++) begin
      run(int'($urandom_range(3)), 16'($urandom_range(16'hFFFF, 16'h3000)),
          int'($urandom_range(NR - 1)), int'($urandom_range(MAXF + 1)),
          int'($urandom_range(20, 5)), int'($urandom_range(100, 30)),
          -1, -1, -1, big, hh);
    end

    // Hotspot share over a long run: roughly 1/8 plus the uniform share.
    run(3, 16'hFFFF, 6, 1, 4096, 100, -1, -1, -1, big, hh);
    pct = (hh * 1000) / 4096;
    check("hot_share_in_range", 64'(pct >= 130 && pct <= 240), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/axis_tg_multimode.md
Name: axis_tg_multimode

Overview:
Synthesizable, parametrised AXI-Stream traffic generator for NoC characterisation (mesh, torus and similar topologies). It is the successor to the single-flit uniform-random simulation generator. It adds multi-flit packets, four destination patterns, and an LFSR-driven Bernoulli injection process that is usable on FPGA. One instance drives each router's input port, and a separate checker consumes the traffic at the destination.

Parameters:
TDATA_WIDTH, 64, flit data width; must be >= TICK_WIDTH + COUNT_WIDTH
TDEST_WIDTH, 4, destination id width
TID_WIDTH, 4, source id width
COUNT_WIDTH, 32, packet counter width
TICK_WIDTH, 32, timestamp width
NUM_ROUTERS, 16, number of endpoints (legal destinations are 0..NUM_ROUTERS-1)
TID, 0, this source's id
SEED, 1, 16-bit LFSR seed; a value of 0 is replaced by 1
MAX_PKT_FLITS, 8, maximum flits per packet

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
load  in  16  injection probability, as load/65535
mode  in  2  0 uniform, 1 fixed, 2 complement, 3 hotspot
hotspot_dest  in  TDEST_WIDTH  destination for modes 1 and 3
pkt_flits  in  $clog2(MAX_PKT_FLITS+1)  flits per packet
num_packets  in  COUNT_WIDTH  packets to send per run
start  in  1  run enable (level)
ticks  in  TICK_WIDTH  global timestamp
done  out  1  run complete
total_sent_packets  out  COUNT_WIDTH  packets whose tlast flit has completed its handshake
axis_out_tvalid  out  1  AXIS valid
axis_out_tready  in  1  AXIS ready
axis_out_tdata  out  TDATA_WIDTH  payload
axis_out_tlast  out  1  last flit of packet
axis_out_tid  out  TID_WIDTH  constant TID
axis_out_tdest  out  TDEST_WIDTH  packet destination

Behaviour:
- Reset (asynchronous, rst_n=0): FSM=IDLE; LFSR=SEED (or 1 if SEED=0); tvalid, tlast, done, tdata, tdest and total_sent_packets all 0; tid=TID.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. It advances every cycle outside IDLE and never holds 0.
- FSM states IDLE -> ARB -> SEND -> ARB, ..., and DONE.
  - IDLE -> ARB on start=1.
  - ARB, per cycle:
    - If total_sent_packets == num_packets: go to DONE.
    - Else if start=0: go to IDLE.
    - Else if lfsr <= load: begin a packet and go to SEND. lfsr never equals 0, so load=0 never injects and load=0xFFFF injects every ARB cycle.
  - At packet start, latch:
    - flits = clamp(pkt_flits, 1, MAX_PKT_FLITS); 0 is treated as 1.
    - ts = ticks.
    - tdest, by mode:
      - 0: lfsr[15:8] % NUM_ROUTERS.
      - 1: hotspot_dest.
      - 2: NUM_ROUTERS-1-TID.
      - 3: hotspot_dest if lfsr[2:0]==0, else the uniform value.
  - tvalid rises the cycle after the ARB decision (1-cycle injection latency).
  - SEND:
    - Flit k (0-based): tdata[TICK_WIDTH-1:0] = ts; tdata[TICK_WIDTH+COUNT_WIDTH-1:TICK_WIDTH] = total_sent_packets; remaining MSBs = k.
    - tlast=1 iff k == flits-1.
    - While tvalid=1 and tready=0, tdata, tdest and tlast hold stable.
    - On each handshake, k increments.
    - On the tlast handshake: total_sent_packets+1, tvalid drops, return to ARB. There are no back-to-back packets without an ARB cycle, so the maximum flit rate is flits/(flits+1).
  - A start deassertion mid-packet never truncates the packet; the FSM finishes SEND, then the ARB cycle goes to IDLE.
  - DONE: done=1, tvalid=0. Leave DONE only when start=0: clear done and total_sent_packets, go to IDLE.
- num_packets=0 with start=1: IDLE -> ARB -> DONE; done=1 two cycles after start.
- total_sent_packets wraps modulo 2^COUNT_WIDTH. The wrap is not reached in practice because the run ends at num_packets.
- Reset asserted mid-packet: all outputs clear immediately. No partial packet resumes after reset.

Test Plan:
- mode=1, hotspot_dest=5, load=0xFFFF, pkt_flits=1, num_packets=4, tready=1 -> 4 flits, one every 2 cycles, each tdest=5 and tlast=1. done=1 after the 4th handshake; total_sent_packets=4.
- load=0, start=1 for 1000 cycles -> tvalid never asserts; done=0; total_sent_packets=0.
- pkt_flits=3, tready held low for 10 cycles mid-packet -> tvalid, tdata and tdest stable for all 10 cycles. tlast only on flit index 2. total_sent_packets increments once, on the third handshake.
- mode=2, TID=3, NUM_ROUTERS=16 -> every packet has tdest=12. pkt_flits=0 -> single-flit packets; pkt_flits=MAX_PKT_FLITS+1 -> clamped to MAX_PKT_FLITS flits.
- mode=3, load=0xFFFF, 4096 packets -> about 12.5% plus the uniform share (~1/16) go to hotspot_dest; all tdest < NUM_ROUTERS; header ts is nondecreasing.
- rst_n pulsed low during flit 1 of a 4-flit packet -> outputs 0 in the same cycle. After release with start=1, the next packet begins at flit 0 and total_sent_packets=0.
